// File: rtl/ir_bank_pkg.sv
// Shared definitions for the double-buffered instruction register bank:
// commit state encoding and default geometry.
package ir_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        COPY = 2'd2
    } commit_state_e;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_PCW   = 8;

endpackage : ir_bank_pkg

// File: rtl/ir_bank_copy_fsm.sv
// Commit sequencer for ir_bank_dbuf: waits for a fetch-free cycle, flips the
// active bank, then walks a copy index across every entry so the new shadow
// bank is rebuilt from the new active bank.
module ir_bank_copy_fsm
    import ir_bank_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          commit,
    input  logic          fetch_req,
    output commit_state_e state,
    output logic [AW-1:0] copy_idx,
    output logic          active_bank,
    output logic          commit_busy
);

    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1'b1);

    commit_state_e state_r;
    commit_state_e state_nxt_s;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] idx_nxt_s;
    logic          bank_r;
    logic          bank_nxt_s;
    logic          busy_r;

    // Next-state, copy index and bank-select decode.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        bank_nxt_s  = bank_r;
        case (state_r)
            IDLE: begin
                if (commit) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                // Swap only on a cycle with no fetch in flight so a fetch
                // never straddles the bank flip.
                if (!fetch_req) begin
                    state_nxt_s = COPY;
                    bank_nxt_s  = ~bank_r;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            COPY: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = '0;
                end else begin
                    idx_nxt_s   = idx_r + IDX_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // State, index, bank-select and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            bank_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            bank_r  <= bank_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign state       = state_r;
    assign copy_idx    = idx_r;
    assign active_bank = bank_r;
    assign commit_busy = busy_r;

endmodule : ir_bank_copy_fsm

// File: rtl/ir_bank_dbuf.sv
// Double-buffered instruction register bank. Config writes land in the shadow
// bank, the FSM op unit fetches from the active bank, and a commit swaps the
// banks then re-synchronises the shadow from the new active bank.
// Optional build macro: IR_READBACK_EN adds a registered shadow-bank readback
// port (cfg_rd_en / cfg_rdata).
module ir_bank_dbuf
    import ir_bank_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int PCW   = DEF_PCW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wt_en,
    input  logic [AW-1:0] cfg_sel,
    input  logic [DW-1:0] din,
    input  logic          commit,
    output logic          commit_busy,
    output logic          wr_drop,
    input  logic          fetch_req,
    input  logic [PCW-1:0] pc_sel,
    output logic          fetch_vld,
    output logic [DW-1:0] pcdata,
    output logic          fetch_err,
    output logic          active_bank
`ifdef IR_READBACK_EN
    ,
    input  logic          cfg_rd_en,
    output logic [DW-1:0] cfg_rdata
`endif
);

    localparam logic [AW:0]  DEPTH_AW  = (AW + 1)'(DEPTH);
    localparam logic [PCW:0] DEPTH_PCW = (PCW + 1)'(DEPTH);

    logic [DW-1:0] bank_r [2][DEPTH];

    commit_state_e state_s;
    logic [AW-1:0] copy_idx_s;
    logic          active_bank_s;
    logic          shadow_s;
    logic          cfg_ok_s;
    logic          pc_ok_s;
    logic          wr_acc_s;
    logic          copy_en_s;

    logic          wr_drop_r;
    logic          fetch_vld_r;
    logic          fetch_err_r;
    logic [DW-1:0] pcdata_r;

    ir_bank_copy_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_copy_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit      (commit),
        .fetch_req   (fetch_req),
        .state       (state_s),
        .copy_idx    (copy_idx_s),
        .active_bank (active_bank_s),
        .commit_busy (commit_busy)
    );

    // Range checks and write/copy qualification.
    always_comb begin
        shadow_s  = ~active_bank_s;
        cfg_ok_s  = ({1'b0, cfg_sel} < DEPTH_AW);
        pc_ok_s   = ({1'b0, pc_sel} < DEPTH_PCW);
        copy_en_s = (state_s == COPY);
        if (wt_en && (state_s == IDLE) && cfg_ok_s) begin
            wr_acc_s = 1'b1;
        end else begin
            wr_acc_s = 1'b0;
        end
    end

    // Bank storage: shadow is written either by the copy walk or by config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bank_r[b][i] <= '0;
                end
            end
        end else if (copy_en_s) begin
            bank_r[shadow_s][copy_idx_s] <= bank_r[active_bank_s][copy_idx_s];
        end else if (wr_acc_s) begin
            bank_r[shadow_s][cfg_sel] <= din;
        end
    end

    // Flag config writes that were discarded (busy or out of range).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop_r <= 1'b0;
        end else begin
            wr_drop_r <= wt_en & ~wr_acc_s;
        end
    end

    // Registered fetch path; data holds between requests, error is qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_vld_r <= 1'b0;
            fetch_err_r <= 1'b0;
            pcdata_r    <= '0;
        end else if (fetch_req) begin
            fetch_vld_r <= 1'b1;
            if (pc_ok_s) begin
                fetch_err_r <= 1'b0;
                pcdata_r    <= bank_r[active_bank_s][pc_sel[AW-1:0]];
            end else begin
                fetch_err_r <= 1'b1;
                pcdata_r    <= '0;
            end
        end else begin
            fetch_vld_r <= 1'b0;
            fetch_err_r <= 1'b0;
        end
    end

`ifdef IR_READBACK_EN
    logic [DW-1:0] cfg_rdata_r;

    // Shadow-bank readback; same-cycle write to the entry returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rdata_r <= '0;
        end else if (cfg_rd_en) begin
            if (cfg_ok_s) begin
                cfg_rdata_r <= bank_r[shadow_s][cfg_sel];
            end else begin
                cfg_rdata_r <= '0;
            end
        end
    end

    assign cfg_rdata = cfg_rdata_r;
`endif

    assign wr_drop     = wr_drop_r;
    assign fetch_vld   = fetch_vld_r;
    assign fetch_err   = fetch_err_r;
    assign pcdata      = pcdata_r;
    assign active_bank = active_bank_s;

endmodule : ir_bank_dbuf

// File: doc/ir_bank_dbuf.md
Name: ir_bank_dbuf

Overview:
Parametrised, double-buffered instruction register bank between the APB config registers and the FSM op unit.
- APB-side writes land in a shadow bank while the FSM fetches from the active bank.
- A commit request swaps the banks at a fetch-free cycle, then copies the new active bank into the new shadow so both banks match.
- Fetch is a registered request/valid path with an out-of-range error flag.

Parameters:
DW, 32, instruction word width
DEPTH, 32, entries per bank (2..256; need not be a power of two)
AW, $clog2(DEPTH), cfg_sel width (derived; not overridden)
PCW, 8, pc_sel width (PCW >= AW)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wt_en  in  1  config write strobe (APB reg)
cfg_sel  in  AW  config write index
din  in  DW  config write data
commit  in  1  single-cycle pulse requesting shadow->active swap
commit_busy  out  1  commit in progress (state != IDLE)
wr_drop  out  1  1-cycle pulse: the previous cycle's write was discarded
fetch_req  in  1  FSM fetch request
pc_sel  in  PCW  FSM fetch index
fetch_vld  out  1  fetch data valid (1 cycle)
pcdata  out  DW  fetched instruction
fetch_err  out  1  qualifies fetch_vld: pc_sel was out of range
active_bank  out  1  index of the bank the FSM fetches from

Behaviour:
- Reset (async assert, sync release): both banks all-zero, active_bank=0, state IDLE, copy index 0. All outputs 0. Reset mid-operation aborts any commit and clears all contents.
- Storage: bank[2][DEPTH] of DW flops. Shadow bank = !active_bank.
- Write:
  - Accepted only in IDLE with cfg_sel < DEPTH; the entry updates on the next edge.
  - A write in any other state, or with cfg_sel >= DEPTH, is discarded and pulses wr_drop on the next cycle.
- Fetch:
  - fetch_req in cycle N samples pc_sel and active_bank.
  - In N+1: fetch_vld=1 and pcdata = active[pc_sel]. If pc_sel >= DEPTH, pcdata=0 and fetch_err=1.
  - Back-to-back requests give one result per cycle.
  - pcdata holds its last value while fetch_vld=0. fetch_err is 0 whenever fetch_vld=0.
- Commit FSM:
  - IDLE: commit=1 -> WAIT. A wt_en in the same cycle as commit is accepted first, so it is included in the swap.
  - WAIT: first cycle with fetch_req=0 -> toggle active_bank, enter COPY with idx=0. fetch_req=1 keeps WAIT; fetches are still served from the old bank.
  - COPY: each cycle shadow[idx] <= active[idx], idx++. When idx==DEPTH-1 -> IDLE. COPY lasts DEPTH cycles.
  - Fetches during COPY read the new active bank (separate read port, unaffected by the copy).
  - commit is ignored in WAIT and COPY.
- Commit latency: from commit accept to IDLE = (cycles in WAIT) + 1 + DEPTH.

Optional Feature:
IR_READBACK_EN
- Defined: adds ports cfg_rd_en (in, 1) and cfg_rdata (out, DW).
  - cfg_rd_en in cycle N returns shadow[cfg_sel] in N+1 (0 if out of range). cfg_rdata is held otherwise and resets to 0.
  - A read in the same cycle as a write to the same entry returns the old value.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package ir_bank_pkg: commit state enum (IDLE, WAIT, COPY), default DW/DEPTH/PCW constants.
- One natural sub-module, ir_bank_copy_fsm: commit FSM, copy index counter, toggling of active_bank.
- Storage and the fetch pipeline stay in the top module.

Test Plan:
1. Reset, then fetch_req with pc_sel=5 -> next cycle fetch_vld=1, pcdata=0, fetch_err=0, active_bank=0.
2. Write din=0xA5A5_0001 to cfg_sel=3; fetch pc_sel=3 -> pcdata=0 (shadow only). Then commit; after WAIT+1+32 cycles commit_busy=0, active_bank=1; fetch pc_sel=3 -> pcdata=0xA5A5_0001.
3. Commit issued while fetch_req is held high 4 cycles -> active_bank toggles only after fetch_req drops. The 4 fetches return old-bank data.
4. wt_en during commit_busy, and wt_en with cfg_sel=31 when DEPTH=24 -> wr_drop pulses once per write; entries are unchanged (verified after the next commit).
5. fetch_req with pc_sel=40 (DEPTH=32) -> fetch_vld=1, fetch_err=1, pcdata=0. Back-to-back fetches of pc_sel=1,2,3 -> three consecutive valid cycles with the matching data.
6. Assert rst_n=0 at COPY idx=10 -> immediately state IDLE, commit_busy=0, active_bank=0, all entries 0.
